// File: rtl/duck_game_engine.sv
// Multi-target Duck Hunt shooting core: magazine, reload, per-duck fall timers,
// score and game-over, all on the pixel clock with registered outputs.
module duck_game_engine #(
    parameter int NUM_DUCKS     = 2,
    parameter int DUCK_W        = 96,
    parameter int DUCK_H        = 32,
    parameter int MAG_SIZE      = 8,
    parameter int SCORE_W       = 7,
    parameter int SCORE_MAX     = 99,
    parameter int COUNTDOWN_CYC = 260_000_000,
    parameter int SHOT_CYC      = 6_500_000,
    parameter int RELOAD_CYC    = 6_500_000,
    parameter int FALL_CYC      = 130_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    game_enable,
    input  logic                    left_mouse,
    input  logic                    right_mouse,
    input  logic [11:0]             mouse_xpos,
    input  logic [11:0]             mouse_ypos,
    input  logic [12*NUM_DUCKS-1:0] target_xpos,
    input  logic [12*NUM_DUCKS-1:0] target_ypos,
    input  logic [NUM_DUCKS-1:0]    target_valid,
    output logic [3:0]              bullets_count,
    output logic                    reload_enable,
    output logic [SCORE_W-1:0]      score,
    output logic [NUM_DUCKS-1:0]    duck_hit,
    output logic [NUM_DUCKS-1:0]    duck_falling,
    output logic                    game_over
);

    localparam int TMR_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_COUNTDOWN, S_HUNTING, S_COOLDOWN, S_RELOAD, S_GAME_OVER
    } state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [3:0]           bullets_q, bullets_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 reload_q, reload_d;
    logic                 game_over_q, game_over_d;
    logic [NUM_DUCKS-1:0] hit_q, hit_d;
    logic [NUM_DUCKS-1:0] falling_q, falling_d;
    logic [TMR_W-1:0]     fall_cnt_q [NUM_DUCKS];
    logic [TMR_W-1:0]     fall_cnt_d [NUM_DUCKS];
    logic                 left_q, left_d, lprev_q, lprev_d;
    logic                 right_q, right_d, rprev_q, rprev_d;

    logic                 left_press, right_press;
    logic [NUM_DUCKS-1:0] kill_oh;
    logic                 kill_found;

    assign left_press  = left_q & ~lprev_q;
    assign right_press = right_q & ~rprev_q;

    // One-hot kill select: lowest-index candidate whose hit-box holds the cursor.
    always_comb begin
        logic [12:0] mx, my, tx, ty;
        kill_oh    = '0;
        kill_found = 1'b0;
        mx = {1'b0, mouse_xpos};
        my = {1'b0, mouse_ypos};
        for (int i = 0; i < NUM_DUCKS; i++) begin
            tx = {1'b0, target_xpos[12*i +: 12]};
            ty = {1'b0, target_ypos[12*i +: 12]};
            if (!kill_found && target_valid[i] && !falling_q[i] &&
                mx >= tx && mx < tx + 13'(DUCK_W) &&
                my >= ty && my < ty + 13'(DUCK_H)) begin
                kill_oh[i] = 1'b1;
                kill_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bullets_d   = bullets_q;
        score_d     = score_q;
        reload_d    = reload_q;
        game_over_d = game_over_q;
        hit_d       = '0;
        falling_d   = falling_q;
        fall_cnt_d  = fall_cnt_q;
        left_d      = left_mouse;
        right_d     = right_mouse;
        lprev_d     = left_q;
        rprev_d     = right_q;

        if (state_q != S_IDLE) begin
            for (int i = 0; i < NUM_DUCKS; i++) begin
                if (falling_q[i]) begin
                    if (fall_cnt_q[i] == '0) falling_d[i] = 1'b0;
                    else                     fall_cnt_d[i] = fall_cnt_q[i] - 1'b1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (game_enable) begin
                    state_d     = S_COUNTDOWN;
                    timer_d     = TMR_W'(COUNTDOWN_CYC - 1);
                    score_d     = '0;
                    bullets_d   = 4'(MAG_SIZE);
                    reload_d    = 1'b0;
                    game_over_d = 1'b0;
                    falling_d   = '0;
                    for (int i = 0; i < NUM_DUCKS; i++) fall_cnt_d[i] = '0;
                end
            end
            S_COUNTDOWN, S_COOLDOWN: begin
                if (timer_q == '0) state_d = S_HUNTING;
                else               timer_d = timer_q - 1'b1;
            end
            S_HUNTING: begin
                if (left_press) begin
                    if (bullets_q == 4'd0) begin
                        reload_d = 1'b1;
                    end else begin
                        bullets_d = bullets_q - 4'd1;
                        state_d   = S_COOLDOWN;
                        timer_d   = TMR_W'(SHOT_CYC - 1);
                        if (kill_found) begin
                            hit_d     = kill_oh;
                            falling_d = falling_d | kill_oh;
                            for (int i = 0; i < NUM_DUCKS; i++)
                                if (kill_oh[i]) fall_cnt_d[i] = TMR_W'(FALL_CYC - 1);
                            score_d = score_q + 1'b1;
                            if (score_q + 1'b1 == SCORE_W'(SCORE_MAX)) begin
                                game_over_d = 1'b1;
                                state_d     = S_GAME_OVER;
                            end
                        end
                    end
                end else if (right_press && bullets_q != 4'(MAG_SIZE)) begin
                    state_d = S_RELOAD;
                    timer_d = TMR_W'(RELOAD_CYC - 1);
                end
            end
            S_RELOAD: begin
                if (timer_q == '0) begin
                    state_d   = S_HUNTING;
                    bullets_d = 4'(MAG_SIZE);
                    reload_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: ;
        endcase

        // Abort wins over anything the running state decided this cycle.
        if (state_q != S_IDLE && !game_enable) begin
            state_d     = S_IDLE;
            bullets_d   = bullets_q;
            score_d     = score_q;
            reload_d    = reload_q;
            game_over_d = game_over_q;
            hit_d       = '0;
            falling_d   = '0;
            for (int i = 0; i < NUM_DUCKS; i++) fall_cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bullets_q   <= 4'(MAG_SIZE);
            score_q     <= '0;
            reload_q    <= 1'b0;
            game_over_q <= 1'b0;
            hit_q       <= '0;
            falling_q   <= '0;
            for (int i = 0; i < NUM_DUCKS; i++) fall_cnt_q[i] <= '0;
            left_q      <= 1'b0;
            lprev_q     <= 1'b0;
            right_q     <= 1'b0;
            rprev_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bullets_q   <= bullets_d;
            score_q     <= score_d;
            reload_q    <= reload_d;
            game_over_q <= game_over_d;
            hit_q       <= hit_d;
            falling_q   <= falling_d;
            for (int i = 0; i < NUM_DUCKS; i++) fall_cnt_q[i] <= fall_cnt_d[i];
            left_q      <= left_d;
            lprev_q     <= lprev_d;
            right_q     <= right_d;
            rprev_q     <= rprev_d;
        end
    end

    assign bullets_count = bullets_q;
    assign reload_enable = reload_q;
    assign score         = score_q;
    assign duck_hit      = hit_q;
    assign duck_falling  = falling_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_duck_game_engine.sv
// Directed bench for duck_game_engine: table of single clicks in HUNTING plus
// hand sequences for countdown, reload, overlap, win/abort and async reset.
module tb_duck_game_engine;

    localparam int FALL = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        game_enable = 1'b0;
    logic        left_mouse = 1'b0;
    logic        right_mouse = 1'b0;
    logic [11:0] mouse_xpos = '0;
    logic [11:0] mouse_ypos = '0;
    logic [23:0] target_xpos = '0;
    logic [23:0] target_ypos = '0;
    logic [1:0]  target_valid = '0;
    logic [3:0]  bullets_count;
    logic        reload_enable;
    logic [6:0]  score;
    logic [1:0]  duck_hit;
    logic [1:0]  duck_falling;
    logic        game_over;

    int n_tests = 0;
    int n_fail  = 0;

    duck_game_engine #(
        .NUM_DUCKS(2), .DUCK_W(96), .DUCK_H(32), .MAG_SIZE(8), .SCORE_W(7),
        .SCORE_MAX(3), .COUNTDOWN_CYC(40), .SHOT_CYC(4), .RELOAD_CYC(6),
        .FALL_CYC(FALL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_enable(game_enable),
        .left_mouse(left_mouse), .right_mouse(right_mouse),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .target_xpos(target_xpos), .target_ypos(target_ypos),
        .target_valid(target_valid), .bullets_count(bullets_count),
        .reload_enable(reload_enable), .score(score), .duck_hit(duck_hit),
        .duck_falling(duck_falling), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        l;
        logic        r;
        logic [11:0] mx;
        logic [11:0] my;
        logic [1:0]  vld;
        logic [3:0]  b;
        logic [6:0]  sc;
        logic [1:0]  hit;
        logic        rl;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    // Raw level high for one edge; the action edge is two edges after the call.
    task automatic press(input logic l, input logic r);
        left_mouse  = l;
        right_mouse = r;
        tick();
        left_mouse  = 1'b0;
        right_mouse = 1'b0;
        tick();
    endtask

    task automatic set_ducks(input logic [11:0] x0, input logic [11:0] y0,
                             input logic [11:0] x1, input logic [11:0] y1);
        target_xpos = {x1, x0};
        target_ypos = {y1, y0};
    endtask

    initial begin
        int c;
        vecs[0] = '{1'b1, 1'b0, 12'd110, 12'd60,  2'b11, 4'd7, 7'd1, 2'b01, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 12'd99,  12'd60,  2'b11, 4'd6, 7'd1, 2'b00, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 12'd196, 12'd60,  2'b11, 4'd5, 7'd1, 2'b00, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 12'd195, 12'd81,  2'b11, 4'd4, 7'd2, 2'b01, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 12'd400, 12'd332, 2'b11, 4'd3, 7'd2, 2'b00, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 12'd400, 12'd300, 2'b01, 4'd2, 7'd2, 2'b00, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 12'd496, 12'd331, 2'b11, 4'd1, 7'd2, 2'b00, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 12'd399, 12'd300, 2'b11, 4'd0, 7'd2, 2'b00, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 12'd0,   12'd0,   2'b11, 4'd0, 7'd2, 2'b00, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 12'd0,   12'd0,   2'b11, 4'd0, 7'd2, 2'b00, 1'b1};

        // Reset values
        #12;
        chk("rst_bullets", bullets_count, 8);
        chk("rst_score", score, 0);
        chk("rst_reload", reload_enable, 0);
        chk("rst_hit", duck_hit, 0);
        chk("rst_falling", duck_falling, 0);
        chk("rst_game_over", game_over, 0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores clicks
        press(1'b1, 1'b0);
        wait_n(2);
        chk("idle_click_bullets", bullets_count, 8);

        // Game 1: a press landing on the countdown's last edge is discarded
        set_ducks(12'd100, 12'd50, 12'd400, 12'd300);
        target_valid = 2'b11;
        game_enable = 1'b1;
        tick();
        wait_n(38);
        press(1'b1, 1'b0);
        chk("countdown_edge40_ignored", bullets_count, 8);

        for (int i = 0; i < 10; i++) begin
            mouse_xpos   = vecs[i].mx;
            mouse_ypos   = vecs[i].my;
            target_valid = vecs[i].vld;
            press(vecs[i].l, vecs[i].r);
            chk($sformatf("v%0d_bullets", i), bullets_count, vecs[i].b);
            chk($sformatf("v%0d_score", i), score, vecs[i].sc);
            chk($sformatf("v%0d_hit", i), duck_hit, vecs[i].hit);
            chk($sformatf("v%0d_reload", i), reload_enable, vecs[i].rl);
            wait_n(8);
        end
        chk("reload_done_bullets", bullets_count, 8);
        chk("reload_done_prompt", reload_enable, 0);

        // Right press at full magazine is ignored: a shot one edge later lands
        mouse_xpos = 12'd0;
        mouse_ypos = 12'd0;
        right_mouse = 1'b1;
        tick();
        right_mouse = 1'b0;
        left_mouse  = 1'b1;
        tick();
        left_mouse  = 1'b0;
        tick();
        chk("full_right_ignored", bullets_count, 7);
        wait_n(8);

        // Clicks during cooldown do nothing
        press(1'b1, 1'b0);
        chk("shot_before_cooldown", bullets_count, 6);
        press(1'b1, 1'b0);
        chk("cooldown_click", bullets_count, 6);
        wait_n(8);

        // Abort holds score and bullets
        game_enable = 1'b0;
        tick();
        chk("abort_score_held", score, 2);
        chk("abort_bullets_held", bullets_count, 6);
        chk("abort_game_over", game_over, 0);
        press(1'b1, 1'b0);
        chk("abort_idle_click", bullets_count, 6);

        // Game 2: restart, first accepted edge is 41 after start
        set_ducks(12'd200, 12'd200, 12'd200, 12'd200);
        target_valid = 2'b11;
        mouse_xpos = 12'd210;
        mouse_ypos = 12'd210;
        game_enable = 1'b1;
        tick();
        chk("restart_score", score, 0);
        chk("restart_bullets", bullets_count, 8);
        wait_n(39);
        press(1'b1, 1'b0);
        chk("g2_k1_bullets", bullets_count, 7);
        chk("g2_k1_score", score, 1);
        chk("g2_k1_hit", duck_hit, 2'b01);
        chk("g2_k1_falling", duck_falling, 2'b01);
        tick();
        chk("g2_hit_one_cycle", duck_hit, 2'b00);
        c = 1;
        wait_n(5);
        c += 5;
        press(1'b1, 1'b0);
        c += 2;
        chk("g2_k2_hit", duck_hit, 2'b10);
        chk("g2_k2_score", score, 2);
        chk("g2_k2_falling", duck_falling, 2'b11);
        while (duck_falling[0] && c < 100) begin
            tick();
            c++;
        end
        chk("g2_fall_width", c, FALL);
        chk("g2_d1_still_falling", duck_falling[1], 1);

        // Third kill reaches the winning score
        wait_n(2);
        press(1'b1, 1'b0);
        chk("win_score", score, 3);
        chk("win_game_over", game_over, 1);
        chk("win_hit", duck_hit, 2'b01);
        chk("win_bullets", bullets_count, 5);
        wait_n(8);
        press(1'b1, 1'b0);
        chk("gameover_click_bullets", bullets_count, 5);
        chk("gameover_click_score", score, 3);
        game_enable = 1'b0;
        tick();
        chk("win_abort_score", score, 3);
        chk("win_abort_game_over", game_over, 1);
        chk("win_abort_falling", duck_falling, 2'b00);
        game_enable = 1'b1;
        tick();
        chk("g3_score", score, 0);
        chk("g3_bullets", bullets_count, 8);
        chk("g3_game_over", game_over, 0);

        // Game 3: kill, then asynchronous reset in the middle of a reload
        wait_n(39);
        press(1'b1, 1'b0);
        chk("g3_kill_score", score, 1);
        wait_n(6);
        press(1'b0, 1'b1);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_bullets", bullets_count, 8);
        chk("areset_score", score, 0);
        chk("areset_falling", duck_falling, 0);
        chk("areset_reload", reload_enable, 0);
        chk("areset_hit", duck_hit, 0);
        chk("areset_game_over", game_over, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
